// File: rtl/fast_vram_slot_sched.sv
// Fast VRAM slot scheduler: 4-slot round (S0/S1 renderer, S2 writer-or-parser, S3 CPU) on one RAM port.
// Latency: read data and strobes one CLK after the SLOT_EN that ends the slot (slot period + 1 CLK).
// Backpressure: none; renderer/parser/writer are served only in their slot, CPU holds CPU_BUSY until served.
//
// Ports:
//   CLK, RESETP            clock, async active-low reset
//   SLOT_EN, LINE_START    slot boundary strobe; LINE_START with SLOT_EN restarts the round at S0
//   REND_*                 renderer read address in, field/data/valid out
//   PARSE_*                Y-parser read request/address in, data/valid out
//   ACTW_*                 active-list write request/address/data in, done pulse out
//   CPU_*                  CPU request in, busy/ack/read data out
//   FVRAM_*, CWE           RAM address, write data, read data, active-low write enable
//
// Build option: define FVRAM_SCHED_CPU_STEAL_EN to let a pending CPU access use an otherwise idle S2.
module fast_vram_slot_sched #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESETP,
  input  logic              SLOT_EN,
  input  logic              LINE_START,
  input  logic [ADDR_W-1:0] REND_ADDR,
  output logic              REND_VALID,
  output logic              REND_FIELD,
  output logic [DATA_W-1:0] REND_RDATA,
  input  logic              PARSE_REQ,
  input  logic [ADDR_W-1:0] PARSE_ADDR,
  output logic              PARSE_VALID,
  output logic [DATA_W-1:0] PARSE_RDATA,
  input  logic              ACTW_REQ,
  input  logic [ADDR_W-1:0] ACTW_ADDR,
  input  logic [DATA_W-1:0] ACTW_DATA,
  output logic              ACTW_DONE,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_BUSY,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic [ADDR_W-1:0] FVRAM_ADDR,
  output logic [DATA_W-1:0] FVRAM_DATA_OUT,
  input  logic [DATA_W-1:0] FVRAM_DATA_IN,
  output logic              CWE
);

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} slot_t;
  typedef enum logic [2:0] {OP_IDLE, OP_REND, OP_PARSE, OP_ACTW, OP_CPU} op_t;

  slot_t             slot_q, slot_d;
  op_t               op_q, op_d;
  logic              field_q, field_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d;

  logic              cpu_we_q;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic [DATA_W-1:0] cpu_wdata_q;

  logic              cpu_avail;
  logic              wr_slot;

  // A CPU access finishing at this SLOT_EN must not be issued again in the next slot.
  assign cpu_avail = CPU_BUSY && (op_q != OP_CPU);
  assign wr_slot   = (op_q == OP_ACTW) || ((op_q == OP_CPU) && cpu_we_q);

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      slot_q  <= S3;
      op_q    <= OP_IDLE;
      field_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      op_q    <= op_d;
      field_q <= field_d;
    end
  end

  // Next slot and the access it will carry; everything is decided at the SLOT_EN that opens it.
  always_comb begin
    slot_d  = slot_q;
    op_d    = op_q;
    field_d = field_q;
    addr_d  = FVRAM_ADDR;
    dout_d  = FVRAM_DATA_OUT;
    if (SLOT_EN) begin
      slot_d = LINE_START ? S0 : slot_t'(slot_q + 2'd1);
      op_d   = OP_IDLE;
      unique case (slot_d)
        S0, S1: begin
          op_d    = OP_REND;
          addr_d  = REND_ADDR;
          field_d = (slot_d == S1);
        end
        S2: begin
          if (ACTW_REQ) begin
            op_d   = OP_ACTW;
            addr_d = ACTW_ADDR;
            dout_d = ACTW_DATA;
          end else if (PARSE_REQ) begin
            op_d   = OP_PARSE;
            addr_d = PARSE_ADDR;
          end
`ifdef FVRAM_SCHED_CPU_STEAL_EN
          else if (cpu_avail) begin
            op_d   = OP_CPU;
            addr_d = cpu_addr_q;
            if (cpu_we_q) dout_d = cpu_wdata_q;
          end
`endif
        end
        S3: begin
          if (cpu_avail) begin
            op_d   = OP_CPU;
            addr_d = cpu_addr_q;
            if (cpu_we_q) dout_d = cpu_wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETP) begin
    if (!RESETP) begin
      REND_VALID     <= 1'b0;
      REND_FIELD     <= 1'b0;
      REND_RDATA     <= '0;
      PARSE_VALID    <= 1'b0;
      PARSE_RDATA    <= '0;
      ACTW_DONE      <= 1'b0;
      CPU_BUSY       <= 1'b0;
      CPU_ACK        <= 1'b0;
      CPU_RDATA      <= '0;
      cpu_we_q       <= 1'b0;
      cpu_addr_q     <= '0;
      cpu_wdata_q    <= '0;
      FVRAM_ADDR     <= '0;
      FVRAM_DATA_OUT <= '0;
      CWE            <= 1'b1;
    end else begin
      REND_VALID     <= 1'b0;
      PARSE_VALID    <= 1'b0;
      ACTW_DONE      <= 1'b0;
      CPU_ACK        <= 1'b0;
      FVRAM_ADDR     <= addr_d;
      FVRAM_DATA_OUT <= dout_d;

      // CWE rises at the slot boundary and falls one CLK later, giving address setup
      // and no write-enable overlap between consecutive write slots.
      if (SLOT_EN)      CWE <= 1'b1;
      else if (wr_slot) CWE <= 1'b0;

      if (SLOT_EN) begin
        unique case (op_q)
          OP_REND: begin
            REND_VALID <= 1'b1;
            REND_FIELD <= field_q;
            REND_RDATA <= FVRAM_DATA_IN;
          end
          OP_PARSE: begin
            PARSE_VALID <= 1'b1;
            PARSE_RDATA <= FVRAM_DATA_IN;
          end
          OP_ACTW: ACTW_DONE <= 1'b1;
          OP_CPU: begin
            CPU_ACK <= 1'b1;
            if (!cpu_we_q) CPU_RDATA <= FVRAM_DATA_IN;
          end
          default: ;
        endcase
      end

      if (SLOT_EN && (op_q == OP_CPU)) begin
        CPU_BUSY <= 1'b0;
      end else if (CPU_REQ && !CPU_BUSY) begin
        CPU_BUSY    <= 1'b1;
        cpu_we_q    <= CPU_WE;
        cpu_addr_q  <= CPU_ADDR;
        cpu_wdata_q <= CPU_WDATA;
      end
    end
  end

endmodule

// File: tb/tb_fast_vram_slot_sched.sv
// Bench for fast_vram_slot_sched: directed scenarios then randomized slots against a slot-level model.
// Latency: model predicts strobes/data one CLK after each ending SLOT_EN.
// Backpressure: CPU requests are only pulsed; the model tracks the pending access.
module tb_fast_vram_slot_sched;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int K_IDLE = 0, K_REND = 1, K_PARSE = 2, K_ACTW = 3, K_CPU = 4;

  logic          CLK = 1'b0;
  logic          RESETP, SLOT_EN, LINE_START;
  logic [AW-1:0] REND_ADDR, PARSE_ADDR, ACTW_ADDR, CPU_ADDR, FVRAM_ADDR;
  logic [DW-1:0] REND_RDATA, PARSE_RDATA, ACTW_DATA, CPU_WDATA, CPU_RDATA;
  logic [DW-1:0] FVRAM_DATA_OUT, FVRAM_DATA_IN;
  logic          REND_VALID, REND_FIELD, PARSE_REQ, PARSE_VALID, ACTW_REQ, ACTW_DONE;
  logic          CPU_REQ, CPU_WE, CPU_BUSY, CPU_ACK, CWE;

  always #5 CLK = ~CLK;

  fast_vram_slot_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESETP(RESETP), .SLOT_EN(SLOT_EN), .LINE_START(LINE_START),
    .REND_ADDR(REND_ADDR), .REND_VALID(REND_VALID), .REND_FIELD(REND_FIELD), .REND_RDATA(REND_RDATA),
    .PARSE_REQ(PARSE_REQ), .PARSE_ADDR(PARSE_ADDR), .PARSE_VALID(PARSE_VALID), .PARSE_RDATA(PARSE_RDATA),
    .ACTW_REQ(ACTW_REQ), .ACTW_ADDR(ACTW_ADDR), .ACTW_DATA(ACTW_DATA), .ACTW_DONE(ACTW_DONE),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_BUSY(CPU_BUSY), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
    .FVRAM_ADDR(FVRAM_ADDR), .FVRAM_DATA_OUT(FVRAM_DATA_OUT), .FVRAM_DATA_IN(FVRAM_DATA_IN), .CWE(CWE)
  );

  // Background RAM content is a fixed address hash until a location is written.
  function automatic logic [15:0] pat(input logic [10:0] a);
    logic [15:0] t;
    t = {5'd0, a};
    return (t * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Physical RAM attached to the port.
  logic [DW-1:0] ram     [0:2047];
  logic          wr_flag [0:2047];
  logic          clr_ram;
  assign FVRAM_DATA_IN = wr_flag[FVRAM_ADDR] ? ram[FVRAM_ADDR] : pat(FVRAM_ADDR);
  always @(posedge CLK) begin
    if (clr_ram) begin
      for (int i = 0; i < 2048; i++) wr_flag[i] <= 1'b0;
    end else if (!CWE) begin
      ram[FVRAM_ADDR]     <= FVRAM_DATA_OUT;
      wr_flag[FVRAM_ADDR] <= 1'b1;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:2047];
  bit            ref_wr  [0:2047];
  int            m_slot, m_kind;
  bit            m_we, m_wr;
  logic [AW-1:0] m_addr, c_addr;
  logic [DW-1:0] m_wdat, c_wdat;
  bit            m_field, c_we;
  // Expected outputs.
  bit            e_rv, e_field, e_pv, e_done, e_busy, e_ack, e_cwe;
  logic [DW-1:0] e_rdat, e_pdat, e_crd, e_dout;
  logic [AW-1:0] e_addr;

  int n_chk = 0, n_fail = 0;
  int cwe_cnt, pv_cnt, ack_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : pat(a);
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    ref_wr[a]  = 1'b1;
  endtask

  task automatic model_reset();
    m_slot = 3; m_kind = K_IDLE; m_wr = 0;
    e_rv = 0; e_field = 0; e_pv = 0; e_done = 0; e_busy = 0; e_ack = 0; e_cwe = 1;
    e_rdat = '0; e_pdat = '0; e_crd = '0; e_dout = '0; e_addr = '0;
  endtask

  // One CLK of the scheduling rules, evaluated on the inputs seen at the rising edge.
  task automatic model_step();
    bit served, pending;
    served = 0;
    e_rv = 0; e_pv = 0; e_done = 0; e_ack = 0;
    if (SLOT_EN) begin
      case (m_kind)
        K_REND:  begin e_rv = 1; e_rdat = ref_rd(m_addr); e_field = m_field; end
        K_PARSE: begin e_pv = 1; e_pdat = ref_rd(m_addr); end
        K_ACTW:  begin e_done = 1; ref_write(m_addr, m_wdat); end
        K_CPU:   begin
          e_ack = 1; served = 1;
          if (m_we) ref_write(m_addr, m_wdat); else e_crd = ref_rd(m_addr);
        end
        default: ;
      endcase
      pending = e_busy && !served;
      m_slot  = LINE_START ? 0 : (m_slot + 1) % 4;
      m_kind  = K_IDLE;
      if (m_slot < 2) begin
        m_kind = K_REND; m_addr = REND_ADDR; m_field = (m_slot == 1);
      end else if (m_slot == 2) begin
        if (ACTW_REQ)       begin m_kind = K_ACTW; m_addr = ACTW_ADDR; m_wdat = ACTW_DATA; end
        else if (PARSE_REQ) begin m_kind = K_PARSE; m_addr = PARSE_ADDR; end
`ifdef FVRAM_SCHED_CPU_STEAL_EN
        else if (pending)   m_kind = K_CPU;
`endif
      end else if (pending) begin
        m_kind = K_CPU;
      end
      if (m_kind == K_CPU) begin m_addr = c_addr; m_wdat = c_wdat; m_we = c_we; end
      if (m_kind != K_IDLE) e_addr = m_addr;
      m_wr = (m_kind == K_ACTW) || (m_kind == K_CPU && m_we);
      if (m_wr) e_dout = m_wdat;
      e_cwe = 1;
    end else if (m_wr) begin
      e_cwe = 0;
    end
    if (served) e_busy = 0;
    else if (CPU_REQ && !e_busy) begin
      e_busy = 1; c_we = CPU_WE; c_addr = CPU_ADDR; c_wdat = CPU_WDATA;
    end
  endtask

  task automatic compare_all();
    chk("rend_valid", REND_VALID, e_rv);
    chk("rend_field", REND_FIELD, e_field);
    chk("rend_rdata", REND_RDATA, e_rdat);
    chk("parse_valid", PARSE_VALID, e_pv);
    chk("parse_rdata", PARSE_RDATA, e_pdat);
    chk("actw_done", ACTW_DONE, e_done);
    chk("cpu_busy", CPU_BUSY, e_busy);
    chk("cpu_ack", CPU_ACK, e_ack);
    chk("cpu_rdata", CPU_RDATA, e_crd);
    chk("fvram_addr", FVRAM_ADDR, e_addr);
    chk("cwe", CWE, e_cwe);
    if (!e_cwe) chk("fvram_dout", FVRAM_DATA_OUT, e_dout);
    chk("one_strobe", (int'(REND_VALID) + int'(PARSE_VALID) + int'(ACTW_DONE) + int'(CPU_ACK)) <= 1, 1);
    if (!CWE) cwe_cnt++;
    if (PARSE_VALID) pv_cnt++;
    if (CPU_ACK) ack_cnt++;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESETP) model_step();
    @(negedge CLK);
    compare_all();
  endtask

  // len CLKs with SLOT_EN on the last one.
  task automatic run_slot(input int len);
    for (int c = 0; c < len; c++) begin
      SLOT_EN = (c == len - 1);
      tick();
    end
    SLOT_EN = 0;
  endtask

  task automatic cpu_pulse(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    CPU_REQ = 1; CPU_WE = we; CPU_ADDR = a; CPU_WDATA = d;
    tick();
    CPU_REQ = 0;
  endtask

  initial begin
    RESETP = 0; SLOT_EN = 0; LINE_START = 0; REND_ADDR = '0; PARSE_REQ = 0; PARSE_ADDR = '0;
    ACTW_REQ = 0; ACTW_ADDR = '0; ACTW_DATA = '0; CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = '0; CPU_WDATA = '0;
    clr_ram = 1;
    for (int i = 0; i < 2048; i++) begin ref_mem[i] = '0; ref_wr[i] = 0; end
    model_reset();
    repeat (3) tick();
    clr_ram = 0;
    RESETP = 1;

    // Renderer reads, CPU write queued during S0.
    REND_ADDR = 11'h123;
    run_slot(4);                                  // enter S0
    cpu_pulse(1, 11'h7FF, 16'hBEEF);
    chk("t3_busy_set", CPU_BUSY, 1);
    run_slot(3);                                  // end S0
    chk("t1_rv0", REND_VALID, 1);
    chk("t1_field0", REND_FIELD, 0);
    chk("t1_rdata0", REND_RDATA, pat(11'h123));
    ACTW_REQ = 1; PARSE_REQ = 1; ACTW_ADDR = 11'h600; ACTW_DATA = 16'h00A5; PARSE_ADDR = 11'h600;
    run_slot(4);                                  // end S1, enter S2 (write wins)
    chk("t1_field1", REND_FIELD, 1);
    ACTW_REQ = 0;
    cwe_cnt = 0; pv_cnt = 0;
    run_slot(4);                                  // end S2
    chk("t2_done", ACTW_DONE, 1);
    chk("t2_cwe_low", cwe_cnt, 3);
    chk("t2_no_parse", pv_cnt, 0);
    run_slot(4);                                  // end S3: CPU write
    chk("t3_ack", CPU_ACK, 1);
    chk("t3_busy_clr", CPU_BUSY, 0);
    cpu_pulse(0, 11'h7FF, 16'h0000);
    run_slot(3);
    run_slot(4);                                  // enter S2 with parser only
    PARSE_REQ = 0;
    run_slot(4);
    chk("t2_parse_valid", PARSE_VALID, 1);
    chk("t2_parse_data", PARSE_RDATA, 16'h00A5);
    run_slot(4);
    chk("t3_rd_ack", CPU_ACK, 1);
    chk("t3_rd_data", CPU_RDATA, 16'hBEEF);

    // LINE_START at the end of S1 restarts the round; CPU stays pending.
    cpu_pulse(0, 11'h123, 16'h0000);
    run_slot(3);                                  // end S0
    ack_cnt = 0; pv_cnt = 0;
    LINE_START = 1;
    run_slot(4);                                  // end S1 -> S0
    LINE_START = 0;
    run_slot(4);                                  // end S0
    chk("t4_rv_field0", REND_FIELD, 0);
    chk("t4_no_ack", ack_cnt, 0);
    chk("t4_busy_kept", CPU_BUSY, 1);

    // Reset in the middle of a write slot, with the CPU access still pending.
    ACTW_REQ = 1; ACTW_ADDR = 11'h155; ACTW_DATA = 16'h1234;
    run_slot(4);                                  // end S1, enter S2 write
    ACTW_REQ = 0;
    repeat (3) tick();
    chk("t5_cwe_low", CWE, 0);
    RESETP = 0;
    #1;
    chk("t5_cwe_async", CWE, 1);
    chk("t5_busy_drop", CPU_BUSY, 0);
    chk("t5_no_ack", CPU_ACK, 0);
    ref_write(11'h155, 16'h1234);                 // the RAM already took the write
    model_reset();
    repeat (2) tick();
    RESETP = 1;
    ack_cnt = 0;
    repeat (5) run_slot(4);                       // S0,S1,S2,S3,S0
    chk("t5_no_late_ack", ack_cnt, 0);

`ifdef FVRAM_SCHED_CPU_STEAL_EN
    cpu_pulse(0, 11'h155, 16'h0000);
    run_slot(3);
    run_slot(4);                                  // enter S2, nothing else requesting
    run_slot(4);
    chk("t6_steal_ack", CPU_ACK, 1);
    chk("t6_steal_data", CPU_RDATA, 16'h1234);
`endif

    // Randomized slots against the model.
    for (int s = 0; s < 400; s++) begin
      int len;
      len = $urandom_range(2, 6);
      for (int c = 0; c < len; c++) begin
        REND_ADDR  = AW'($urandom_range(0, 31));
        PARSE_REQ  = ($urandom_range(0, 2) == 0);
        PARSE_ADDR = AW'($urandom_range(0, 31));
        ACTW_REQ   = ($urandom_range(0, 3) == 0);
        ACTW_ADDR  = AW'($urandom_range(0, 31));
        ACTW_DATA  = DW'($urandom);
        CPU_REQ    = ($urandom_range(0, 4) == 0);
        CPU_WE     = $urandom_range(0, 1) == 1;
        CPU_ADDR   = AW'($urandom_range(0, 31));
        CPU_WDATA  = DW'($urandom);
        LINE_START = ($urandom_range(0, 7) == 0);
        SLOT_EN    = (c == len - 1);
        tick();
      end
    end
    SLOT_EN = 0; CPU_REQ = 0; ACTW_REQ = 0; PARSE_REQ = 0; LINE_START = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fast_vram_slot_sched.md
# fast_vram_slot_sched

Time-slot scheduler and arbiter for the 2K×16 fast VRAM port used by the sprite pipeline. It divides each slot period into a fixed 4-slot round: two renderer reads, one slot shared by the Y parser and the active-list writer, and one CPU slot. It drives the single address/data/CWE port and returns read data with per-requester valid strobes. It replaces ad-hoc per-phase address muxing with one registered, arbitrated sequencer.

## Interface
Parameters:
- ADDR_W, 11, fast VRAM address width
- DATA_W, 16, fast VRAM data width

Ports:
- CLK  in  1  system clock; all logic runs on its rising edge
- RESETP  in  1  asynchronous, active-low reset
- SLOT_EN  in  1  one-CLK strobe that ends the current slot and starts the next; at least 2 CLK apart
- LINE_START  in  1  sampled only with SLOT_EN; forces the next slot to S0
- REND_ADDR  in  ADDR_W  renderer read address, sampled at the start of S0 and S1
- REND_VALID  out  1  one-CLK pulse at the end of S0/S1; REND_RDATA valid
- REND_FIELD  out  1  0 = data from S0, 1 = data from S1
- REND_RDATA  out  DATA_W  renderer read data
- PARSE_REQ / PARSE_ADDR  in  1 / ADDR_W  Y-parser read request (level) and address
- PARSE_VALID / PARSE_RDATA  out  1 / DATA_W  one-CLK pulse with read data
- ACTW_REQ / ACTW_ADDR / ACTW_DATA  in  1 / ADDR_W / DATA_W  active-list write request
- ACTW_DONE  out  1  one-CLK pulse when the write slot completes
- CPU_REQ / CPU_WE / CPU_ADDR / CPU_WDATA  in  1/1/ADDR_W/DATA_W  CPU access request
- CPU_BUSY  out  1  CPU request latched and pending
- CPU_ACK / CPU_RDATA  out  1 / DATA_W  one-CLK completion pulse; read data (reads only)
- FVRAM_ADDR  out  ADDR_W  RAM address
- FVRAM_DATA_OUT / FVRAM_DATA_IN  out / in  DATA_W  RAM write/read data
- CWE  out  1  RAM write enable, active low

## Operation
- The 2-bit slot counter runs S0→S1→S2→S3→S0 and advances on each SLOT_EN. LINE_START together with SLOT_EN loads S0.
- S0/S1: read REND_ADDR. Data is captured into REND_RDATA on the SLOT_EN that ends the slot, with REND_VALID pulsed.
- S2 arbitration uses requests sampled at the SLOT_EN that starts S2:
  - ACTW_REQ wins over PARSE_REQ and performs a write, then ACTW_DONE.
  - Otherwise PARSE_REQ performs a read, then PARSE_VALID.
  - With neither request, the slot is idle.
- CPU path:
  - When CPU_REQ=1 and CPU_BUSY=0, CPU_WE, CPU_ADDR and CPU_WDATA are latched and CPU_BUSY is set the next CLK. CPU_REQ is ignored while busy.
  - In S3 with CPU_BUSY=1, the latched access executes. At slot end CPU_ACK pulses, CPU_BUSY clears, and CPU_RDATA is updated for reads only.
  - With CPU_BUSY=0, S3 is idle.
- Idle slot: FVRAM_ADDR holds its previous value, CWE=1, no strobes.
- Only one of REND_VALID, PARSE_VALID, ACTW_DONE or CPU_ACK fires per SLOT_EN.

## Timing
- Reset values:
  - slot counter = S3, so the first SLOT_EN enters S0
  - CWE=1, CPU_BUSY=0, all pulses 0
  - FVRAM_ADDR=0, FVRAM_DATA_OUT=0, REND_RDATA=0, PARSE_RDATA=0, CPU_RDATA=0
- Slot start (CLK after SLOT_EN): FVRAM_ADDR and FVRAM_DATA_OUT are registered and held for the whole slot.
- Write slots: CWE goes low from the second CLK of the slot and returns high on the CLK after the ending SLOT_EN. This gives one CLK of address setup and no CWE overlap across slots.
- Read data is sampled from FVRAM_DATA_IN in the same CLK as the ending SLOT_EN. Strobes and RDATA appear the following CLK.
- Read latency: slot period plus 1 CLK.
- A CPU request latched during S3 waits for the next S3; it is never served mid-slot.
- LINE_START during S2 or S3:
  - If the slot is ending normally, it completes with its strobe.
  - If LINE_START arrives mid-round, it never truncates the current slot, because it acts only at a SLOT_EN.
- RESETP assertion mid-write forces CWE=1 immediately (asynchronously) and drops any pending CPU access without CPU_ACK.

## Configuration
- FVRAM_SCHED_CPU_STEAL_EN:
  - Defined: an S2 slot with neither ACTW_REQ nor PARSE_REQ sampled executes a pending CPU access, with CPU_ACK at the end of S2. S3 is then idle unless a new request is latched before S3 starts.
  - Undefined: the CPU is served in S3 only.

## Test plan
- Reset, then SLOT_EN every 4 CLK with REND_ADDR=0x123 -> first slot S0 reads 0x123; REND_VALID pulses with REND_FIELD=0, then again with REND_FIELD=1; CWE stays 1 throughout.
- ACTW_REQ and PARSE_REQ both high at S2 start with ACTW_ADDR=0x600, ACTW_DATA=0x00A5 -> write 0x00A5 to 0x600, CWE low for 3 CLK, ACTW_DONE pulses, no PARSE_VALID; PARSE is served in the next round.
- CPU write 0x7FF←0xBEEF raised during S0 -> CPU_BUSY next CLK, write in S3, CPU_ACK at S3 end. A subsequent CPU read of 0x7FF returns CPU_RDATA=0xBEEF.
- LINE_START with the SLOT_EN that ends S1 -> next slot is S0, no S2/S3 strobes, and a pending CPU request stays pending with CPU_BUSY=1.
- RESETP low during CWE=0 -> CWE=1 in the same cycle, CPU_BUSY=0, slot=S3, no CPU_ACK.
- With FVRAM_SCHED_CPU_STEAL_EN defined, S2 with no parser or writer requests and a pending CPU read -> CPU_ACK at S2 end.
